// File: rtl/fir_out_quant.sv
// fir_out_quant: rounds and saturates a 38-bit FIR accumulator to Q15 samples,
// buffered through a first-word-fall-through FIFO with registered backpressure.
`default_nettype none

module fir_out_quant #(
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic signed [37:0] sum_in,
  input  logic               sum_valid,
  output logic               sum_ready,
  output logic signed [15:0] dout,
  output logic               dout_valid,
  input  logic               out_ready,
  output logic               dout_sat,
  output logic [15:0]        sat_count,
  output logic               overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [38:0] RND_OFFSET = 39'sd1 <<< (SHIFT - 1);
  localparam logic signed [38:0] SAT_MAX    = 39'sd32767;
  localparam logic signed [38:0] SAT_MIN    = -39'sd32768;
  localparam logic [CW-1:0]      FULL_LEVEL = CW'(DEPTH);

  logic               accept;
  logic               pop;
  logic signed [38:0] sum_wide;
  logic signed [38:0] sum_rounded;
  logic signed [38:0] q_shifted;

  logic               s1_valid;
  logic signed [38:0] s1_r;
  logic signed [15:0] clamp_sample;
  logic               clamp_sat;

  logic               s2_valid;
  logic signed [15:0] s2_sample;
  logic               s2_sat;

  logic [16:0]        mem [DEPTH];
  logic [16:0]        head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic [CW-1:0]      occ;

  // Occupancy includes in-flight pipeline words, so the FIFO can never overrun.
  assign sum_ready  = (occ < FULL_LEVEL);
  assign dout_valid = (fifo_cnt != '0);
  assign pop        = dout_valid & out_ready;
  assign accept     = sum_valid & sum_ready;

  assign sum_wide    = {sum_in[37], sum_in};
  assign sum_rounded = sum_wide + RND_OFFSET;
  assign q_shifted   = sum_rounded >>> SHIFT;

  always_comb begin
    clamp_sample = s1_r[15:0];
    clamp_sat    = 1'b0;
    if (s1_r > SAT_MAX) begin
      clamp_sample = 16'sh7FFF;
      clamp_sat    = 1'b1;
    end else if (s1_r < SAT_MIN) begin
      clamp_sample = 16'sh8000;
      clamp_sat    = 1'b1;
    end
  end

  assign head     = mem[rd_ptr];
  assign dout     = dout_valid ? $signed(head[15:0]) : 16'sd0;
  assign dout_sat = dout_valid & head[16];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_r         <= '0;
      s2_valid     <= 1'b0;
      s2_sample    <= '0;
      s2_sat       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      occ          <= '0;
      sat_count    <= '0;
      overflow_err <= 1'b0;
    end else begin
      s1_valid  <= accept;
      if (accept) s1_r <= q_shifted;

      s2_valid  <= s1_valid;
      if (s1_valid) begin
        s2_sample <= clamp_sample;
        s2_sat    <= clamp_sat;
      end

      if (s2_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);

      case ({s2_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      case ({accept, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase

      if (s2_valid && s2_sat && (sat_count != 16'hFFFF))
        sat_count <= sat_count + 16'd1;

      if (sum_valid && !sum_ready)
        overflow_err <= 1'b1;
    end
  end

  // Storage carries no reset; dout is gated by dout_valid instead.
  always_ff @(posedge clk1) begin
    if (s2_valid) mem[wr_ptr] <= {s2_sat, s2_sample};
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_out_quant.sv
// tb_fir_out_quant: directed vectors for fir_out_quant with a pop-side scoreboard.
`default_nettype none

module tb_fir_out_quant;

  logic               clk1 = 1'b0;
  logic               rst;
  logic signed [37:0] sum_in;
  logic               sum_valid;
  logic               sum_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               out_ready;
  logic               dout_sat;
  logic [15:0]        sat_count;
  logic               overflow_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];

  fir_out_quant #(.SHIFT(15), .DEPTH(8)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .sum_in      (sum_in),
    .sum_valid   (sum_valid),
    .sum_ready   (sum_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .out_ready   (out_ready),
    .dout_sat    (dout_sat),
    .sat_count   (sat_count),
    .overflow_err(overflow_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic signed [39:0] got, input logic signed [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every popped sample must match the oldest accepted word.
  always @(negedge clk1) begin
    if (!rst && dout_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        chk("dout", dout, $signed(exp_q[0][15:0]));
        chk("dout_sat", dout_sat, exp_q[0][16]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Called just after a rising edge; the word is offered on the following edge.
  task automatic offer(input logic signed [37:0] s, input logic signed [15:0] v,
                       input logic sat, output int acc);
    sum_in    = s;
    sum_valid = 1'b1;
    acc       = sum_ready ? 1 : 0;
    if (sum_ready) exp_q.push_back({sat, v});
    step();
    sum_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk1);
    chk("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin
    int acc;
    int nacc;
    rst       = 1'b1;
    sum_in    = '0;
    sum_valid = 1'b0;
    out_ready = 1'b0;

    @(negedge clk1);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_sat", dout_sat, 0);
    chk("rst_satcnt", sat_count, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_ready", sum_ready, 1);
    step();
    rst = 1'b0;
    step();

    // Latency: one word, no pops until it is visible.
    sum_in    = 38'sd163840;
    sum_valid = 1'b1;
    chk("lat_ready", sum_ready, 1);
    exp_q.push_back({1'b0, 16'sd5});
    step();
    sum_valid = 1'b0;
    @(negedge clk1); chk("lat_n0", dout_valid, 0);
    @(negedge clk1); chk("lat_n1", dout_valid, 0);
    @(negedge clk1); chk("lat_n2", dout_valid, 1);
    chk("lat_dout", dout, 5);
    step();
    out_ready = 1'b1;
    wait_drain();

    // Rounding around the half-LSB point.
    offer(38'sd16384,  16'sd1,  1'b0, acc);
    offer(38'sd16383,  16'sd0,  1'b0, acc);
    offer(-38'sd16384, 16'sd0,  1'b0, acc);
    offer(-38'sd16385, -16'sd1, 1'b0, acc);
    wait_drain();

    // Saturation and the clamp boundaries.
    offer(38'sd1073741824,   16'sd32767,  1'b1, acc);
    offer(-38'sd68719476736, -16'sd32768, 1'b1, acc);
    offer(38'sd1073725439,   16'sd32767,  1'b0, acc);
    offer(38'sd1073725440,   16'sd32767,  1'b1, acc);
    offer(-38'sd1073741824,  -16'sd32768, 1'b0, acc);
    wait_drain();
    chk("sat_count", sat_count, 3);

    // Throughput: back-to-back words all accepted.
    nacc = 0;
    for (int k = 40; k < 46; k++) begin
      offer(38'(k * 32768), 16'(k), 1'b0, acc);
      nacc += acc;
    end
    chk("tput_acc", nacc, 6);
    wait_drain();
    chk("pre_ovf", overflow_err, 0);

    // Backpressure: 10 offered, 8 fit.
    out_ready = 1'b0;
    nacc = 0;
    for (int k = 1; k <= 10; k++) begin
      offer(38'(k * 32768), 16'(k), 1'b0, acc);
      nacc += acc;
    end
    chk("bp_acc", nacc, 8);
    chk("bp_ready", sum_ready, 0);
    chk("bp_ovf", overflow_err, 1);
    repeat (3) step();
    chk("bp_head_valid", dout_valid, 1);
    chk("bp_head", dout, 1);
    repeat (2) step();
    chk("bp_head_hold", dout, 1);
    chk("bp_ready_hold", sum_ready, 0);
    out_ready = 1'b1;
    wait_drain();

    // Full FIFO with pops and pushes running together.
    out_ready = 1'b0;
    nacc = 0;
    for (int k = 11; k <= 18; k++) begin
      offer(38'(k * 32768), 16'(k), 1'b0, acc);
      nacc += acc;
    end
    chk("full_fill", nacc, 8);
    repeat (3) step();
    out_ready = 1'b1;
    chk("full_ready", sum_ready, 0);
    nacc = 0;
    for (int k = 19; k <= 30; k++) begin
      offer(38'(k * 32768), 16'(k), 1'b0, acc);
      nacc += acc;
    end
    chk("full_acc", nacc, 11);
    wait_drain();

    // Reset mid-stream with words in flight.
    out_ready = 1'b0;
    for (int k = 50; k < 55; k++) offer(38'(k * 32768), 16'(k), 1'b0, acc);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk1);
    chk("mrst_dout", dout, 0);
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_sat", dout_sat, 0);
    chk("mrst_satcnt", sat_count, 0);
    chk("mrst_ovf", overflow_err, 0);
    chk("mrst_ready", sum_ready, 1);
    step();
    rst = 1'b0;
    step();
    offer(38'sd229476, 16'sd7, 1'b0, acc);
    chk("mrst_acc", acc, 1);
    repeat (3) @(negedge clk1);
    chk("mrst_valid2", dout_valid, 1);
    chk("mrst_dout2", dout, 7);
    step();
    out_ready = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    chk("mrst_alone", dout_valid, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_out_quant.md
FIR_OUT_QUANT -- requirements
Module: fir_out_quant

Interface
REQ-001 The module SHALL have parameter SHIFT, default 15, which sets the arithmetic right-shift applied to the accumulator (Q15 coefficients).
REQ-002 The module SHALL have parameter DEPTH, default 8, which sets the output FIFO depth in words (power of 2, 2..64).
REQ-003 clk1  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 sum_in  input  38  signed FIR accumulator word from the upstream 64-tap core.
REQ-006 sum_valid  input  1  sum_in is valid this cycle.
REQ-007 sum_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  16  signed quantised sample at the FIFO head.
REQ-009 dout_valid  output  1  dout holds a valid sample.
REQ-010 out_ready  input  1  downstream consumes dout when dout_valid and out_ready are both high.
REQ-011 dout_sat  output  1  the sample at the FIFO head was saturated.
REQ-012 sat_count  output  16  count of saturated samples; holds at 0xFFFF and does not wrap.
REQ-013 overflow_err  output  1  sticky flag: a word was offered while sum_ready was low.

Function
REQ-014 A word SHALL be accepted on a rising edge where sum_valid=1 and sum_ready=1.
REQ-015 Stage 1 SHALL register r = (sum_in + 2^(SHIFT-1)) >>> SHIFT, computed at 39 bits with an arithmetic shift (round half up).
REQ-016 Stage 2 SHALL clamp r to [-32768, 32767], set the sample's sat bit if clamping occurred, and write {sat, sample} to the FIFO.
REQ-017 The FIFO SHALL be first-word-fall-through: a word accepted at edge N SHALL show dout_valid=1 after edge N+2 when the FIFO and pipeline are empty.
REQ-018 Occupancy SHALL be counted as FIFO entries plus valid pipeline stages.
REQ-019 sum_ready SHALL be 1 when occupancy < DEPTH and SHALL be driven from registered state only (no combinational path from out_ready).
REQ-020 A pop (dout_valid & out_ready) and a push in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-021 When sum_valid=1 and sum_ready=0, the word SHALL be dropped, overflow_err SHALL set to 1 and stay 1 until reset, and no other state SHALL change.
REQ-022 The FIFO read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by the occupancy count.
REQ-023 With out_ready=0, dout and dout_sat SHALL stay stable while dout_valid=1.
REQ-024 sat_count SHALL increment by 1 when a saturated sample is written to the FIFO, and SHALL saturate at 0xFFFF.
REQ-025 With a continuous sum_valid stream and out_ready held at 1, throughput SHALL be one word per cycle.

Reset
REQ-026 On rst=1, the pipeline valids, FIFO pointers and occupancy SHALL clear immediately and asynchronously, discarding any in-flight words.
REQ-027 Reset values SHALL be: dout=0, dout_valid=0, dout_sat=0, sat_count=0, overflow_err=0, sum_ready=1 (sum_ready effective from the first edge after rst falls).
REQ-028 Asserting rst mid-stream SHALL not cause a partial word or a spurious dout_valid after release.

Verification
REQ-029 Rounding (SHIFT=15, out_ready=1): sum_in = 16384, 16383, -16384, -16385 -> dout = 1, 0, 0, -1 in order, each with dout_sat=0.
REQ-030 Saturation: sum_in = 2^30 -> dout=32767, dout_sat=1; sum_in = -2^36 -> dout=-32768, dout_sat=1; sat_count=2.
REQ-031 Latency: a single word accepted at edge N -> dout_valid rises after edge N+2, with dout equal to the expected quantised value.
REQ-032 Backpressure: out_ready=0 while 10 words are offered -> 8 accepted, sum_ready=0 from then on, overflow_err=1; then out_ready=1 -> 8 samples drain in order.
REQ-033 Simultaneous push and pop at full -> occupancy stays 8, sum_ready stays low (registered), and no data is lost or reordered.
REQ-034 rst pulsed with 5 words in flight -> all outputs return to their reset values; the next word after release emerges alone and correct.
